// File: rtl/rainbow_pkg.sv
// rainbow_pkg: shared constants and state encoding for the rainbow ramp sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rainbow_pkg;

  // Counter width for the tick divider and both per-channel counters.
  localparam int CNT_W = 12;

  // Default PWM period in CLK cycles; it matches the downstream PWM channels.
  localparam int FREQ_DEF = 2400;

  // Default start delays in PWM periods. The triangle period is 2*(FREQ-1) ticks.
  // G sits at about 120 degrees and B at about 240 degrees, both rounded to even.
  localparam int DLY_R_DEF = 0;
  localparam int DLY_G_DEF = 1600;
  localparam int DLY_B_DEF = 3198;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } chan_state_t;

endpackage

// File: rtl/rgb_flag_chan.sv
// rgb_flag_chan: ramp-direction FSM for one PWM channel (WAIT -> UP <-> DOWN) with sticky error.
// Latency: tick or stt_event is acted on at the next CLK edge; flag and err are registered.
// Backpressure: none; every tick and event is consumed in the cycle it is presented.
// Ports: CLK, RST_N (async, active low); tick = PWM duty step cycle; stt_event = rising edge of the
//        channel's duty-at-top; flag = 1 rising / 0 falling; err = sticky protocol error.
module rgb_flag_chan
  import rainbow_pkg::*;
#(
  parameter int FREQ = FREQ_DEF,
  parameter int DLY  = 0          // start delay in ticks; keep it even so WAIT ends on flag=1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  input  logic stt_event,
  output logic flag,
  output logic err
);

  localparam logic [CNT_W-1:0]  DLY_V  = CNT_W'(DLY);
  localparam logic [CNT_W-1:0]  TOP    = CNT_W'(FREQ - 1);
  localparam logic [CNT_W-1:0]  TURN   = CNT_W'(FREQ - 2);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
  localparam chan_state_t       RST_ST = (DLY == 0) ? ST_UP : ST_WAIT;

  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] dly, dly_nxt;
  logic [CNT_W-1:0] dcnt, dcnt_nxt;
  logic             flag_nxt, err_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RST_ST;
      dly   <= DLY_V;
      dcnt  <= '0;
      flag  <= 1'b1;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      dly   <= dly_nxt;
      dcnt  <= dcnt_nxt;
      flag  <= flag_nxt;
      err   <= err_nxt;
    end
  end

  // The stt_event branch is tested before tick in every state: an event wins a same-cycle tick.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    dcnt_nxt  = dcnt;
    flag_nxt  = flag;
    err_nxt   = err;
    unique case (state)
      ST_WAIT: begin
        // The PWM cannot hold its duty, so toggling the direction every tick dithers it 0/1.
        if (stt_event) begin
          err_nxt = 1'b1;
        end else if (tick) begin
          dly_nxt = dly - ONE;
          if (dly == ONE) begin
            state_nxt = ST_UP;
            flag_nxt  = 1'b1;
          end else begin
            flag_nxt = ~flag;
          end
        end
      end
      ST_UP: begin
        flag_nxt = 1'b1;
        if (stt_event) begin
          state_nxt = ST_DOWN;
          flag_nxt  = 1'b0;
          dcnt_nxt  = '0;
        end else if (tick) begin
          // dcnt is the watchdog here: FREQ ticks without reaching the top means the PWM is lost.
          if (dcnt == TOP) begin
            err_nxt  = 1'b1;
            dcnt_nxt = '0;
          end else begin
            dcnt_nxt = dcnt + ONE;
          end
        end
      end
      ST_DOWN: begin
        flag_nxt = 1'b0;
        if (stt_event) begin
          err_nxt = 1'b1;
        end else if (tick) begin
          // The PWM steps down on this same tick and reaches 0.
          // Turning here stops the duty from wrapping.
          if (dcnt == TURN) begin
            state_nxt = ST_UP;
            flag_nxt  = 1'b1;
            dcnt_nxt  = '0;
          end else begin
            dcnt_nxt = dcnt + ONE;
          end
        end
      end
      default: begin
        state_nxt = RST_ST;
      end
    endcase
  end

endmodule

// File: rtl/rainbow_seq.sv
// rainbow_seq: tick divider, STT edge detectors and three phase-shifted ramp FSMs for an RGB PWM.
// Latency: FLAG/ERR respond one CLK edge after the tick or STT event; ERR is the OR of channel flops.
// Backpressure: none; STT inputs are edge-detected and each event is acted on immediately.
// Ports: CLK, RST_N (async, active low); STT_R/G/B = duty-at-top level per PWM channel;
//        FLAG_R/G/B = ramp direction per channel (1 rising); ERR = sticky protocol error.
module rainbow_seq
  import rainbow_pkg::*;
#(
  parameter int FREQ  = FREQ_DEF,
  parameter int DLY_R = DLY_R_DEF,
  parameter int DLY_G = DLY_G_DEF,
  parameter int DLY_B = DLY_B_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic STT_R,
  input  logic STT_G,
  input  logic STT_B,
  output logic FLAG_R,
  output logic FLAG_G,
  output logic FLAG_B,
  output logic ERR
);

  localparam logic [CNT_W-1:0] TOP   = CNT_W'(FREQ - 1);
  localparam logic [CNT_W-1:0] ALIGN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] div;
  logic             tick;
  logic [2:0]       stt, stt_d, stt_ev;
  logic [2:0]       chan_err;

  assign stt    = {STT_B, STT_G, STT_R};
  assign stt_ev = stt & ~stt_d;
  assign tick   = (div == TOP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stt_d <= '0;
    end else begin
      stt_d <= stt;
    end
  end

  // An STT event arrives two cycles after the PWM duty step. Loading 2 puts div back in phase
  // with the PWM period counter, whatever drift the free-running count has built up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
    end else if (|stt_ev) begin
      div <= ALIGN;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + ONE;
    end
  end

  rgb_flag_chan #(.FREQ(FREQ), .DLY(DLY_R)) u_chan_r (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .tick      (tick),
    .stt_event (stt_ev[0]),
    .flag      (FLAG_R),
    .err       (chan_err[0])
  );

  rgb_flag_chan #(.FREQ(FREQ), .DLY(DLY_G)) u_chan_g (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .tick      (tick),
    .stt_event (stt_ev[1]),
    .flag      (FLAG_G),
    .err       (chan_err[1])
  );

  rgb_flag_chan #(.FREQ(FREQ), .DLY(DLY_B)) u_chan_b (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .tick      (tick),
    .stt_event (stt_ev[2]),
    .flag      (FLAG_B),
    .err       (chan_err[2])
  );

  // Each channel error is a sticky flop, so the OR has no combinational input path.
  assign ERR = |chan_err;

endmodule
